// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding, iteration count and a small two's-complement helper.
package mul_div_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ITERATIONS = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Conditionally negate a two's-complement word.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One non-restoring divide iteration on unsigned magnitudes.
// The partial remainder is kept as a 33-bit signed value; the final
// restore and the sign fix-up of quotient and remainder live in the parent.
module mdu_div_core (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;

  // Shift {rem,quo} left, then add or subtract the divisor by remainder sign.
  always_comb begin
    shifted = {rem[31:0], quo[31]};
    if (rem[32]) begin
      rem_next = shifted + {1'b0, divisor};
    end else begin
      rem_next = shifted - {1'b0, divisor};
    end
    quo_next = {quo[30:0], ~rem_next[32]};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (non-restoring).
// Timeline: the start edge loads the operands, the next 32 edges each run
// one iteration, and the following edge applies the result fix-up while
// entering DONE, so done appears 33 edges after the start edge.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_write,
  output logic        div_by_zero
);

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic        iter_end;

  // Latched request and working datapath registers.
  logic        op_lat;
  logic [31:0] a_lat;
  logic [31:0] m_reg;
  logic [32:0] acc;
  logic [31:0] q_reg;
  logic        q_m1;
  logic        q_neg;
  logic        r_neg;
  logic        b_zero;

  // Combinational step results.
  logic [32:0] booth_sum;
  logic [32:0] mul_acc_next;
  logic [31:0] mul_q_next;
  logic [32:0] div_acc_next;
  logic [31:0] div_q_next;
  logic [32:0] rem_fix;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  mdu_div_core u_div_core (
    .rem      (acc),
    .quo      (q_reg),
    .divisor  (m_reg),
    .rem_next (div_acc_next),
    .quo_next (div_q_next)
  );

  // Booth step: add/subtract the sign-extended multiplier, then shift right.
  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + {m_reg[31], m_reg};
      2'b10:   booth_sum = acc - {m_reg[31], m_reg};
      default: booth_sum = acc;
    endcase
    mul_acc_next = {booth_sum[32], booth_sum[32:1]};
    mul_q_next   = {booth_sum[0], q_reg[31:1]};
  end

  // Divide fix-up: restore a negative remainder, then apply result signs.
  always_comb begin
    rem_fix = acc[32] ? (acc + {1'b0, m_reg}) : acc;
    div_lo  = neg_if(q_reg, q_neg);
    div_hi  = neg_if(rem_fix[31:0], r_neg);
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (iter_end) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    hilo_write = (state == ST_DONE);
  end

  // Operand latch, iteration datapath, counter and result registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt         <= '0;
      iter_end    <= 1'b0;
      op_lat      <= OP_MUL;
      a_lat       <= '0;
      m_reg       <= '0;
      acc         <= '0;
      q_reg       <= '0;
      q_m1        <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_lat   <= op;
            a_lat    <= a;
            acc      <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            iter_end <= 1'b0;
            if (op == OP_DIV) begin
              q_reg  <= neg_if(a, a[31]);
              m_reg  <= neg_if(b, b[31]);
              q_neg  <= a[31] ^ b[31];
              r_neg  <= a[31];
              b_zero <= (b == 32'd0);
            end else begin
              q_reg  <= a;
              m_reg  <= b;
              q_neg  <= 1'b0;
              r_neg  <= 1'b0;
              b_zero <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (!iter_end) begin
            if (op_lat == OP_DIV) begin
              acc   <= div_acc_next;
              q_reg <= div_q_next;
            end else begin
              acc   <= mul_acc_next;
              q_reg <= mul_q_next;
            end
            q_m1 <= q_reg[0];
            cnt  <= cnt + 5'd1;
            if (cnt == LAST_ITER) iter_end <= 1'b1;
          end else begin
            // Results are written exactly once, on the edge entering DONE.
            if (op_lat == OP_DIV) begin
              if (b_zero) begin
                hi <= a_lat;
                lo <= 32'hFFFF_FFFF;
              end else begin
                hi <= div_hi;
                lo <= div_lo;
              end
              div_by_zero <= b_zero;
            end else begin
              hi          <= acc[31:0];
              lo          <= q_reg;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        hilo_write;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  int          lat;
  int          ndone;
  int          hw_bad;
  logic [31:0] cap_hi;
  logic [31:0] cap_lo;
  logic        cap_dbz;
  logic        cap_busy;

  mul_div_unit dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .hilo_write  (hilo_write),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble operands afterwards, optionally pulse start
  // again at RUN cycle 'inject', and watch 40 edges for done pulses.
  task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int inject);
    lat = 0; ndone = 0; hw_bad = 0;
    cap_hi = '0; cap_lo = '0; cap_dbz = 1'b0; cap_busy = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~o;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject) begin
        start = 1'b1; a = 32'h1234_5678; b = 32'h0000_0009; op = ~o;
      end
      @(posedge clk); #1;
      if (n == inject) start = 1'b0;
      if (hilo_write !== done) hw_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat = n; cap_hi = hi; cap_lo = lo; cap_dbz = div_by_zero; cap_busy = busy;
        end
      end
    end
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b latency=%0d dones=%0d",
             tag, o, x, y, cap_hi, cap_lo, cap_dbz, lat, ndone);
  endtask

  task automatic check_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input int inject,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz);
    do_op(tag, o, x, y, inject);
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_dones"}, 32'(ndone), 32'd1);
    chk({tag, "_hi"}, cap_hi, exp_hi);
    chk({tag, "_lo"}, cap_lo, exp_lo);
    chk({tag, "_dbz"}, {31'd0, cap_dbz}, {31'd0, exp_dbz});
    chk({tag, "_busy_at_done"}, {31'd0, cap_busy}, 32'd1);
    chk({tag, "_hilo_write_eq_done"}, 32'(hw_bad), 32'd0);
    chk({tag, "_hi_held"}, hi, exp_hi);
    chk({tag, "_lo_held"}, lo, exp_lo);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hilo_write", {31'd0, hilo_write}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;

    check_op("mul_7_m3",    1'b0, 32'd7,          32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    check_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    check_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    check_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 0, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0);
    check_op("div_100_0",   1'b1, 32'd100,        32'd0,         0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    // Abort mid-RUN with clr; outputs from the previous divide must clear.
    op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_hilo_write", {31'd0, hilo_write}, 32'd0);
    chk("clr_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("clr_hi", hi, 32'd0);
    chk("clr_lo", lo, 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("clr_no_done", 32'(ndone), 32'd0);
    $display("txn clr_abort mid-run dones_after=%0d", ndone);

    check_op("mul_3_5_after_clr", 1'b0, 32'd3, 32'd5, 0, 32'h0000_0000, 32'h0000_000F, 1'b0);
    check_op("mul_ignore_start",  1'b0, 32'd1000, 32'd1000, 10, 32'h0000_0000, 32'h000F_4240, 1'b0);
    check_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 1'b0);
    check_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port clr, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-004 SHALL have port op, input, 1, operation select: 0 = signed multiply, 1 = signed divide.
REQ-005 SHALL have port a, input, 32, multiplicand or dividend (two's complement).
REQ-006 SHALL have port b, input, 32, multiplier or divisor (two's complement).
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port hi, output, 32, result high word: product[63:32] or remainder.
REQ-010 SHALL have port lo, output, 32, result low word: product[31:0] or quotient.
REQ-011 SHALL have port hilo_write, output, 1, write strobe for the downstream HI/LO registers; identical to done.
REQ-012 SHALL have port div_by_zero, output, 1, set with done when op=1 and b=0.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on a clk edge with start=1; a, b and op SHALL be latched on that edge.
REQ-015 RUN SHALL last exactly 32 cycles, one iteration per cycle, counted by a 5-bit counter.
REQ-016 RUN -> DONE after the 32nd iteration.
REQ-017 DONE SHALL last one cycle, then return to IDLE.
REQ-018 done SHALL be asserted 33 edges after the edge that sampled start.
REQ-019 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 Operand changes after the latching edge SHALL NOT affect the result.
REQ-022 Multiply: radix-2 Booth algorithm; {hi,lo} = full 64-bit signed product.
REQ-023 Divide: signed, quotient truncated toward zero; lo = quotient; hi = remainder.
REQ-024 Divide remainder sign SHALL equal the dividend sign (or the remainder is 0).
REQ-025 Divide by zero: lo = 32'hFFFFFFFF, hi = a, div_by_zero = 1; same latency as a normal divide.
REQ-026 Divide 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0, div_by_zero = 0.
REQ-027 Multiply -2^31 * -2^31: {hi,lo} = 64'h4000000000000000.
REQ-028 hi and lo SHALL update only on entry to DONE and hold their values until the next completion.
REQ-029 div_by_zero SHALL update with hi and lo and hold until the next completion.

Reset
REQ-030 clr=0 SHALL, asynchronously: force IDLE, clear the counter, and set busy, done, hilo_write, div_by_zero, hi and lo to 0.
REQ-031 clr asserted mid-RUN SHALL abort the operation; no done pulse.
REQ-032 The first start sampled after clr deasserts SHALL be honoured normally.

Structure
REQ-033 A shared package SHALL hold: op encodings (OP_MUL, OP_DIV), state encoding, and constant ITERATIONS = 32.
REQ-034 The per-cycle non-restoring divide step (sign fix-up handled in the parent) SHALL be a single sub-module mdu_div_core.
REQ-035 The multiply datapath and control SHALL reside in mul_div_unit.

Verification
REQ-036 mul a=7, b=-3 -> 33 edges later: done=1 for one cycle, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-037 div a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1), div_by_zero=0.
REQ-038 div a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064, div_by_zero=1.
REQ-039 start pulsed at RUN cycle 10 with new operands -> ignored; result matches the first request; exactly one done.
REQ-040 clr low at RUN cycle 15 -> outputs 0 immediately, no done; a new mul 3*5 then yields lo=15, hi=0.
REQ-041 mul 32'h80000000 * 32'h80000000 -> hi=32'h40000000, lo=0; hilo_write equals done on every cycle.
